dmem_lsu_ctrl: RTL

//  Load/store controller between the RV32I core's MEM stage and the word-wide data memory.

---
 rtl/dmem_lsu_if.sv | 32 +++
 rtl/dmem_lsu_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu_if.sv
// Bundle of core-side request/response and data-memory signals for the
// load/store controller. The controller takes the slave view; the core and
// memory model together take the master view.
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_lsu_ctrl.sv
// Load/store controller between the RV32I MEM stage and a word-wide data
// memory. Byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests become word
// cycles; sub-word stores are done as read-modify-write, loads extract and
// extend the addressed lane. Bad requests answer with an error and never
// touch memory.
module dmem_lsu_ctrl #(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic      clk,
  input  logic      rst,
  dmem_lsu_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WRITE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } state_t;

  // Request legality: funct3 encoding, alignment and word-index range.
  function automatic logic req_error(input logic        we,
                                     input logic [2:0]  f3,
                                     input logic [31:0] addr);
    logic e;
    e = 1'b0;
    case (f3)
      3'b000:  e = 1'b0;
      3'b001:  e = addr[0];
      3'b010:  e = (addr[1:0] != 2'b00);
      3'b100:  e = we;
      3'b101:  e = we | addr[0];
      default: e = 1'b1;
    endcase
    if ({2'b00, addr[31:2]} >= 32'(DEPTH)) begin
      e = 1'b1;
    end else begin
      e = e;
    end
    return e;
  endfunction

  // Pick the addressed byte/half out of a word and sign- or zero-extend it.
  function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                               input logic [1:0]  lo,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Replace only the addressed byte/half lane of a word with store data.
  function automatic logic [31:0] merge_lane(input logic [2:0]  f3,
                                             input logic [1:0]  lo,
                                             input logic [31:0] word,
                                             input logic [31:0] wd);
    logic [31:0] r;
    r = word;
    if (f3 == 3'b000) begin
      case (lo)
        2'd0:    r[7:0]   = wd[7:0];
        2'd1:    r[15:8]  = wd[7:0];
        2'd2:    r[23:16] = wd[7:0];
        2'd3:    r[31:24] = wd[7:0];
        default: r = word;
      endcase
    end else begin
      if (lo[1]) begin
        r[31:16] = wd[15:0];
      end else begin
        r[15:0] = wd[15:0];
      end
    end
    return r;
  endfunction

  state_t            state_r;
  state_t            state_nxt_s;
  logic [2:0]        funct3_r;
  logic [1:0]        addr_lo_r;
  logic [IDX_W-1:0]  idx_r;
  logic [31:0]       wdata_r;
  logic [31:0]       word_r;
  logic [31:0]       rdata_r;
  logic              err_r;
  logic              accept_s;
  logic              err_s;

  assign accept_s = (state_r == IDLE) && bus.req_valid;
  assign err_s    = req_error(bus.req_we, bus.req_funct3, bus.req_addr);

  // State register; reset forces IDLE so memory strobes drop immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; the operation path is chosen at accept time.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (err_s) begin
            state_nxt_s = RESP;
          end else if (!bus.req_we) begin
            state_nxt_s = LOAD;
          end else if (bus.req_funct3 == 3'b010) begin
            state_nxt_s = WRITE;
          end else begin
            state_nxt_s = RMW_RD;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD:    state_nxt_s = RESP;
      WRITE:   state_nxt_s = RESP;
      RMW_RD:  state_nxt_s = RMW_WR;
      RMW_WR:  state_nxt_s = RESP;
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Latch the accepted request; only the bits the datapath needs are kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      funct3_r  <= 3'b000;
      addr_lo_r <= 2'b00;
      idx_r     <= '0;
      wdata_r   <= 32'h0000_0000;
    end else if (accept_s) begin
      funct3_r  <= bus.req_funct3;
      addr_lo_r <= bus.req_addr[1:0];
      idx_r     <= bus.req_addr[IDX_W+1:2];
      wdata_r   <= bus.req_wdata;
    end else begin
      funct3_r  <= funct3_r;
      addr_lo_r <= addr_lo_r;
      idx_r     <= idx_r;
      wdata_r   <= wdata_r;
    end
  end

  // Merge store data into the word read during RMW_RD, ready for RMW_WR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_r <= 32'h0000_0000;
    end else if (state_r == RMW_RD) begin
      word_r <= merge_lane(funct3_r, addr_lo_r, bus.mem_rdata, wdata_r);
    end else begin
      word_r <= word_r;
    end
  end

  // Response data/error are loaded on entry to RESP and held until the next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= 32'h0000_0000;
      err_r   <= 1'b0;
    end else if ((state_r != RESP) && (state_nxt_s == RESP)) begin
      rdata_r <= (state_r == LOAD) ?
                 load_extract(funct3_r, addr_lo_r, bus.mem_rdata) : 32'h0000_0000;
      err_r   <= (state_r == IDLE);
    end else begin
      rdata_r <= rdata_r;
      err_r   <= err_r;
    end
  end

  // Output decode from the state register; strobes are mutually exclusive.
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.busy       = 1'b1;
    bus.resp_valid = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = {{(32-IDX_W){1'b0}}, idx_r};
    bus.mem_wdata  = 32'h0000_0000;
    case (state_r)
      IDLE: begin
        bus.req_ready = 1'b1;
        bus.busy      = 1'b0;
        bus.mem_addr  = 32'h0000_0000;
      end
      LOAD:   bus.mem_read = 1'b1;
      RMW_RD: bus.mem_read = 1'b1;
      WRITE: begin
        bus.mem_write = 1'b1;
        bus.mem_wdata = wdata_r;
      end
      RMW_WR: begin
        bus.mem_write = 1'b1;
        bus.mem_wdata = word_r;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.mem_addr   = 32'h0000_0000;
      end
      default: begin
        bus.busy     = 1'b0;
        bus.mem_addr = 32'h0000_0000;
      end
    endcase
  end

  assign bus.resp_rdata = rdata_r;
  assign bus.resp_err   = err_r;

endmodule
